// File: rtl/pm_phase_gen_pkg.sv
// Shared constants and FSM encoding for the phase-modulated stimulus generator.
// The phase scale (pi = 2^31-1) matches the receive-side deviation measurement.
package pm_phase_gen_pkg;
    localparam int PHASE_W   = 32;
    localparam int DEV_W     = 42;
    localparam int TRI_SHIFT = 30;

    localparam logic signed [PHASE_W-1:0] PI_Q31  = 32'sd2147483647;
    localparam logic signed [DEV_W-1:0]   MAX_DEV = 42'sd10737418235;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pm_state_e;
endpackage

// File: rtl/pm_tri_shaper.sv
// Modulation accumulator folded into a zero-centred triangle, with a pulse
// marking the positive peak (accumulator MSB rising).
module pm_tri_shaper #(
    parameter int W = pm_phase_gen_pkg::PHASE_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    input  logic [W-1:0]        fcw_i,
    output logic signed [W-1:0] tri_o,
    output logic                peak_o
);
    import pm_phase_gen_pkg::*;

    localparam logic [W-1:0] TRI_OFS = W'(1) << (W-2);

    logic [W-1:0] acc_q;
    logic [W-1:0] t_u;
    logic         msb_q;

    // Upper half of the accumulator counts back down: 2^(W-1)-1 - x == ~x.
    always_comb begin
        t_u = {1'b0, (acc_q[W-1] ? ~acc_q[W-2:0] : acc_q[W-2:0])};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            tri_o  <= '0;
            msb_q  <= 1'b0;
            peak_o <= 1'b0;
        end else if (clr_i) begin
            acc_q  <= '0;
            tri_o  <= '0;
            msb_q  <= 1'b0;
            peak_o <= 1'b0;
        end else begin
            acc_q  <= acc_q + fcw_i;
            tri_o  <= $signed(t_u - TRI_OFS);
            msb_q  <= acc_q[W-1];
            peak_o <= acc_q[W-1] & ~msb_q;
        end
    end
endmodule

// File: rtl/pm_phase_gen.sv
// Carrier phase ramp plus triangle-modulated offset, wrapped to a signed phase
// word for a DDS / cos-sin LUT. Four-stage pipeline gated by a small FSM.
module pm_phase_gen #(
    parameter int                          PHASE_WIDTH = pm_phase_gen_pkg::PHASE_W,
    parameter int                          DEV_WIDTH   = pm_phase_gen_pkg::DEV_W,
    parameter logic signed [DEV_WIDTH-1:0] MAX_DEV     = pm_phase_gen_pkg::MAX_DEV
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_load,
    input  logic                        run_en,
    input  logic [PHASE_WIDTH-1:0]      carrier_fcw,
    input  logic [PHASE_WIDTH-1:0]      mod_fcw,
    input  logic signed [DEV_WIDTH-1:0] dev_peak,
    output logic [PHASE_WIDTH-1:0]      phase_out,
    output logic signed [DEV_WIDTH-1:0] mod_phase,
    output logic                        out_valid,
    output logic                        mod_sync,
    output logic                        cfg_err
);
    import pm_phase_gen_pkg::*;

    localparam int PROD_W = DEV_WIDTH + PHASE_WIDTH;

    pm_state_e                   state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0]      car_fcw_q, mod_fcw_q;
    logic signed [DEV_WIDTH-1:0] dev_q, dev_d;
    logic                        cfg_err_q, clamp_hi, clamp_lo;
    logic                        clr, run_c;

    logic [PHASE_WIDTH-1:0]        car_acc_q, car2_q, car3_q, phase_q;
    logic signed [PHASE_WIDTH-1:0] tri_s2;
    logic                          pk_s2, pk3_q, pk4_q;
    logic signed [PROD_W-1:0]      prod_d, prod_q;
    logic signed [DEV_WIDTH-1:0]   mp_d, mp_q;

    always_comb begin
        clamp_hi = dev_peak > MAX_DEV;
        clamp_lo = dev_peak < -MAX_DEV;
        dev_d    = dev_peak;
        if (clamp_hi)      dev_d = MAX_DEV;
        else if (clamp_lo) dev_d = -MAX_DEV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_fcw_q <= '0;
            mod_fcw_q <= '0;
            dev_q     <= '0;
            cfg_err_q <= 1'b0;
        end else if (cfg_load) begin
            car_fcw_q <= carrier_fcw;
            mod_fcw_q <= mod_fcw;
            dev_q     <= dev_d;
            cfg_err_q <= clamp_hi | clamp_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (!run_en) begin
            state_d = ST_IDLE;
        end else if (cfg_load) begin
            state_d = ST_PRIME;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_RUN;
                end
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Any restart or stop empties the pipeline and zeroes both accumulators.
    always_comb begin
        run_c = (state_q == ST_RUN);
        clr   = cfg_load | ~run_en | (state_q == ST_IDLE);
    end

    pm_tri_shaper #(.W(PHASE_WIDTH)) u_tri (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (clr),
        .fcw_i   (mod_fcw_q),
        .tri_o   (tri_s2),
        .peak_o  (pk_s2)
    );

    // Low product bits are sign-agnostic, so an unsigned multiply of the
    // sign-extended operands yields the exact signed product.
    always_comb begin
        prod_d = {{PHASE_WIDTH{dev_q[DEV_WIDTH-1]}}, dev_q}
               * {{DEV_WIDTH{tri_s2[PHASE_WIDTH-1]}}, tri_s2};
        mp_d   = DEV_WIDTH'(prod_q >>> TRI_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_acc_q <= '0;
            car2_q    <= '0;
            car3_q    <= '0;
            prod_q    <= '0;
            pk3_q     <= 1'b0;
            mp_q      <= '0;
            phase_q   <= '0;
            pk4_q     <= 1'b0;
        end else if (clr) begin
            car_acc_q <= '0;
            car2_q    <= '0;
            car3_q    <= '0;
            prod_q    <= '0;
            pk3_q     <= 1'b0;
            mp_q      <= '0;
            phase_q   <= '0;
            pk4_q     <= 1'b0;
        end else begin
            car_acc_q <= car_acc_q + car_fcw_q;
            car2_q    <= car_acc_q;
            car3_q    <= car2_q;
            prod_q    <= prod_d;
            pk3_q     <= pk_s2;
            mp_q      <= mp_d;
            phase_q   <= car3_q + mp_d[PHASE_WIDTH-1:0];
            pk4_q     <= pk3_q;
        end
    end

    assign out_valid = run_c;
    assign phase_out = run_c ? phase_q : '0;
    assign mod_phase = run_c ? mp_q : '0;
    assign mod_sync  = run_c & pk4_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pm_phase_gen.sv
// Scoreboard bench for pm_phase_gen: a behavioural phase model fills a queue
// of expected samples, drained as out_valid samples appear.
module tb_pm_phase_gen;
    logic               clk = 1'b0;
    logic               rst_n, cfg_load, run_en;
    logic [31:0]        carrier_fcw, mod_fcw;
    logic signed [41:0] dev_peak;
    logic [31:0]        phase_out;
    logic signed [41:0] mod_phase;
    logic               out_valid, mod_sync, cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]        ph;
        logic signed [41:0] mp;
        logic               sync;
    } exp_t;

    exp_t               sb[$];
    logic signed [41:0] st_max, st_min;
    int                 st_first_v, st_alias_bad;
    int                 sync_at[$];
    logic [31:0]        ph_hist[$];

    localparam logic signed [41:0] PI   = 42'sd2147483647;
    localparam logic signed [41:0] MAXD = 42'sd10737418235;
    localparam logic signed [41:0] DEV6 = 42'sd12884901882;

    pm_phase_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_load    (cfg_load),
        .run_en      (run_en),
        .carrier_fcw (carrier_fcw),
        .mod_fcw     (mod_fcw),
        .dev_peak    (dev_peak),
        .phase_out   (phase_out),
        .mod_phase   (mod_phase),
        .out_valid   (out_valid),
        .mod_sync    (mod_sync),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample n is the n-th output after a restart (accumulators = n*fcw).
    function automatic exp_t model(input int n, input logic [31:0] cfw, input logic [31:0] mfw,
                                   input logic signed [41:0] dev);
        exp_t               r;
        logic [31:0]        nu, macc, mprev, t;
        logic signed [31:0] tri_v;
        logic signed [73:0] prod, sh;
        nu    = n;
        macc  = mfw * nu;
        mprev = mfw * (nu - 32'd1);
        t     = macc[31] ? (32'h7FFF_FFFF - {1'b0, macc[30:0]}) : {1'b0, macc[30:0]};
        tri_v = $signed(t) - 32'sd1073741824;
        prod  = 74'(dev) * 74'(tri_v);
        sh    = prod >>> 30;
        r.mp  = sh[41:0];
        r.ph  = cfw * nu + r.mp[31:0];
        r.sync = macc[31] & ~mprev[31];
        return r;
    endfunction

    task automatic pulse_cfg(input logic [31:0] cfw, input logic [31:0] mfw, input logic signed [41:0] dev);
        carrier_fcw = cfw;
        mod_fcw     = mfw;
        dev_peak    = dev;
        cfg_load    = 1'b1;
        step();
        cfg_load    = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int nsamp, input logic [31:0] cfw,
                              input logic [31:0] mfw, input logic signed [41:0] dev);
        exp_t e;
        int   cyc = 0;
        int   idx = 0;
        for (int n = 1; n <= nsamp; n++) sb.push_back(model(n, cfw, mfw, dev));
        st_first_v   = -1;
        st_alias_bad = 0;
        st_max       = '0;
        st_min       = '0;
        sync_at.delete();
        ph_hist.delete();
        while (sb.size() > 0 && cyc < nsamp + 20) begin
            step();
            cyc++;
            if (out_valid === 1'b1) begin
                if (st_first_v < 0) st_first_v = cyc;
                idx++;
                e = sb.pop_front();
                checks++;
                if (phase_out !== e.ph || mod_phase !== e.mp || mod_sync !== e.sync) begin
                    errors++;
                    $display("FAIL %s sample %0d: phase_out %h expected %h, mod_phase %0d expected %0d, mod_sync %b expected %b",
                             tag, idx, phase_out, e.ph, mod_phase, e.mp, mod_sync, e.sync);
                end
                if (idx == 1 || mod_phase > st_max) st_max = mod_phase;
                if (idx == 1 || mod_phase < st_min) st_min = mod_phase;
                if (mod_sync === 1'b1) sync_at.push_back(idx);
                if (phase_out !== mod_phase[31:0]) st_alias_bad++;
                ph_hist.push_back(phase_out);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d samples outstanding, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0 || phase_out !== 32'd0 || mod_phase !== 42'sd0 || mod_sync !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid %b phase %h mod_phase %0d sync %b, expected all zero",
                     name, out_valid, phase_out, mod_phase, mod_sync);
        end
    endtask

    task automatic test_reset();
        #3;
        check_idle_outputs("reset_outputs");
        check_int("reset_cfg_err", cfg_err, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_dev_pi();
        run_en = 1'b1;
        pulse_cfg(32'd0, 32'h0100_0000, PI);
        check_int("pi_cfg_err", cfg_err, 0);
        run_stream("dev_pi", 700, 32'd0, 32'h0100_0000, PI);
        check_int("pi_latency", st_first_v, 4);
        // Triangle tops out at 2^30-1, so the positive peak floors to pi-2.
        check_int("pi_max", st_max, PI - 42'sd2);
        check_int("pi_min", st_min, -PI);
        check_int("pi_sync_count", sync_at.size(), 3);
        if (sync_at.size() == 3) begin
            check_int("pi_sync_first", sync_at[0], 128);
            check_int("pi_sync_gap0", sync_at[1] - sync_at[0], 256);
            check_int("pi_sync_gap1", sync_at[2] - sync_at[1], 256);
        end
        check_int("pi_alias", st_alias_bad, 0);
    endtask

    task automatic test_dev_5pi();
        pulse_cfg(32'd0, 32'h0100_0000, MAXD);
        check_int("5pi_cfg_err", cfg_err, 0);
        run_stream("dev_5pi", 300, 32'd0, 32'h0100_0000, MAXD);
        check_int("5pi_latency", st_first_v, 4);
        check_int("5pi_pk2pk", st_max - st_min, 2 * MAXD - 42'sd10);
        check_int("5pi_alias", st_alias_bad, 0);
    endtask

    task automatic test_clamp();
        pulse_cfg(32'd0, 32'h0100_0000, DEV6);
        check_int("clamp_pos_err", cfg_err, 1);
        run_stream("clamp_pos", 300, 32'd0, 32'h0100_0000, MAXD);
        check_int("clamp_pos_min", st_min, -MAXD);
        pulse_cfg(32'd0, 32'h0100_0000, -DEV6);
        check_int("clamp_neg_err", cfg_err, 1);
        run_stream("clamp_neg", 300, 32'd0, 32'h0100_0000, -MAXD);
        check_int("clamp_neg_max", st_max, MAXD);
        pulse_cfg(32'd0, 32'h0100_0000, 42'sd0);
        check_int("clamp_cleared", cfg_err, 0);
    endtask

    task automatic test_carrier();
        logic [31:0] tbl[4];
        tbl = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
        pulse_cfg(32'h4000_0000, 32'd0, 42'sd0);
        run_stream("carrier", 8, 32'h4000_0000, 32'd0, 42'sd0);
        for (int i = 0; i < 8 && i < ph_hist.size(); i++) begin
            checks++;
            if (ph_hist[i] !== tbl[i % 4]) begin
                errors++;
                $display("FAIL carrier_seq[%0d]: got %h expected %h", i, ph_hist[i], tbl[i % 4]);
            end
        end
    endtask

    task automatic test_mfw_zero();
        pulse_cfg(32'h1000_0000, 32'd0, 42'sd1000);
        run_stream("mfw_zero", 20, 32'h1000_0000, 32'd0, 42'sd1000);
        check_int("mfw_zero_max", st_max, -1000);
        check_int("mfw_zero_min", st_min, -1000);
    endtask

    task automatic test_back_to_back();
        pulse_cfg(32'h1000_0000, 32'h0400_0000, 42'sd123456789);
        check_int("b2b_valid_drop", out_valid, 0);
        run_stream("b2b", 100, 32'h1000_0000, 32'h0400_0000, 42'sd123456789);
        check_int("b2b_latency", st_first_v, 4);
    endtask

    task automatic test_run_stop();
        run_en = 1'b0;
        step();
        check_idle_outputs("stop_outputs");
        run_en = 1'b1;
        run_stream("stop_restart", 4, 32'h1000_0000, 32'h0400_0000, 42'sd123456789);
        // Config latched on the same edge that run_en falls.
        run_en = 1'b0;
        pulse_cfg(32'h2000_0000, 32'd0, 42'sd0);
        check_idle_outputs("cfg_and_stop");
        step();
        step();
        check_idle_outputs("stays_idle");
        run_en = 1'b1;
        run_stream("relaunch", 16, 32'h2000_0000, 32'd0, 42'sd0);
        // One IDLE->PRIME cycle, then four PRIME cycles.
        check_int("relaunch_latency", st_first_v, 5);
    endtask

    task automatic test_reset_mid_run();
        pulse_cfg(32'h0800_0000, 32'h0200_0000, DEV6);
        check_int("midrun_cfg_err", cfg_err, 1);
        run_stream("midrun", 10, 32'h0800_0000, 32'h0200_0000, MAXD);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check_int("async_reset_cfg_err", cfg_err, 0);
        #2 rst_n = 1'b1;
        run_stream("post_reset", 20, 32'd0, 32'd0, 42'sd0);
        check_int("post_reset_latency", st_first_v, 5);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_load    = 1'b0;
        run_en      = 1'b0;
        carrier_fcw = '0;
        mod_fcw     = '0;
        dev_peak    = '0;
        test_reset();
        test_dev_pi();
        test_dev_5pi();
        test_clamp();
        test_carrier();
        test_mfw_zero();
        test_back_to_back();
        test_run_stop();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
